// File: rtl/peribus_pkg.sv
// Shared Peribus definitions: master FSM states and the peripheral address map.
package peribus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } peribus_state_t;

    localparam logic [7:0] GPIO_0_BASE  = 8'h00;
    localparam logic [7:0] GPIO_1_BASE  = 8'h04;
    localparam logic [7:0] TIMER_0_BASE = 8'h08;
    localparam logic [7:0] TIMER_1_BASE = 8'h0C;
    localparam logic [7:0] PERIPH_SPAN  = 8'h04;

    localparam int PERIBUS_MAPPED_LIMIT = 'h10;

endpackage

// File: rtl/peribus_master.sv
// Peribus initiator: turns CPU valid/ready load/store requests into timed
// SETUP/ACCESS bus cycles, rejects unmapped addresses and registers irq.
module peribus_master
    import peribus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int WAIT_STATES  = 1,
    parameter int MAPPED_LIMIT = PERIBUS_MAPPED_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  irq,
    output logic                  irq_out
);

    // One extra bit so a limit of 2**ADDR_WIDTH (everything mapped) still compares correctly.
    localparam logic [ADDR_WIDTH:0] LIMIT     = (ADDR_WIDTH+1)'(MAPPED_LIMIT);
    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

    peribus_state_t state, next_state;
    logic [3:0]     wait_count, next_count;
    logic           write_flag;
    logic           accept;
    logic           unmapped;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign unmapped  = ({1'b0, req_addr} >= LIMIT);

    always_comb begin
        next_state = state;
        next_count = wait_count;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = unmapped ? RESP : SETUP;
                    next_count = WAIT_INIT;
                end
            end
            SETUP:  next_state = ACCESS;
            ACCESS: begin
                if (wait_count == 4'd0) next_state = RESP;
                else                    next_count = wait_count - 4'd1;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with ACCESS cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wait_count   <= 4'd0;
            write_flag   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            addr         <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            irq_out      <= 1'b0;
        end else begin
            state        <= next_state;
            wait_count   <= next_count;
            irq_out      <= irq;
            rsp_valid    <= (state == RESP);
            read_enable  <= (next_state == ACCESS) && !write_flag;
            write_enable <= (next_state == ACCESS) && write_flag && (next_count == 4'd0);
            if (accept) begin
                write_flag <= req_write;
                addr       <= req_addr;
                write_data <= req_wdata;
                rsp_error  <= unmapped;
                rsp_rdata  <= '0;
            end else if (state == ACCESS && wait_count == 4'd0 && !write_flag) begin
                rsp_rdata  <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_peribus_master.sv
// Scoreboard bench for peribus_master: directed loads/stores on a WAIT_STATES=1
// instance and a WAIT_STATES=0 instance, checked by per-instance monitors.
module tb_peribus_master;

    typedef struct {
        int          due;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    exp_t sb1[$];
    exp_t sb0[$];
    exp_t e1, e0x;

    logic        req_valid = 0, req_write = 0, req_ready;
    logic [7:0]  req_addr = 0, addr;
    logic [15:0] req_wdata = 0, rsp_rdata, write_data, read_data;
    logic [15:0] rd_value = 16'h0000;
    logic        rsp_valid, rsp_error, write_enable, read_enable;
    logic        irq = 0, irq_out;

    logic        req_valid_0 = 0, req_write_0 = 0, req_ready_0;
    logic [7:0]  req_addr_0 = 0, addr_0;
    logic [15:0] req_wdata_0 = 0, rsp_rdata_0, write_data_0, read_data_0;
    logic [15:0] rd_value_0 = 16'h0000;
    logic        rsp_valid_0, rsp_error_0, write_enable_0, read_enable_0;
    logic        irq_out_0;

    assign read_data   = read_enable   ? rd_value   : 16'hDEAD;
    assign read_data_0 = read_enable_0 ? rd_value_0 : 16'hDEAD;

    peribus_master #(.WAIT_STATES(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .addr(addr), .write_data(write_data),
        .write_enable(write_enable), .read_enable(read_enable),
        .read_data(read_data), .irq(irq), .irq_out(irq_out)
    );

    peribus_master #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid_0), .req_ready(req_ready_0), .req_write(req_write_0),
        .req_addr(req_addr_0), .req_wdata(req_wdata_0),
        .rsp_valid(rsp_valid_0), .rsp_rdata(rsp_rdata_0), .rsp_error(rsp_error_0),
        .addr(addr_0), .write_data(write_data_0),
        .write_enable(write_enable_0), .read_enable(read_enable_0),
        .read_data(read_data_0), .irq(irq), .irq_out(irq_out_0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    int we_count = 0, re_count = 0, overlap = 0;
    logic [7:0]  we_addr = 0;
    logic [15:0] we_data = 0;
    int re_count_0 = 0, we_count_0 = 0;

    // Monitor for the WAIT_STATES=1 instance: responses against the scoreboard, strobes tallied.
    always @(negedge clock) begin
        if (rsp_valid) begin
            if (sb1.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e1 = sb1.pop_front();
                checkOutput("rsp_cycle", cyc, e1.due);
                checkOutput("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e1.rdata});
                checkOutput("rsp_error", {31'd0, rsp_error}, {31'd0, e1.err});
            end
        end
        if (read_enable && write_enable) overlap++;
        if (read_enable_0 && write_enable_0) overlap++;
        if (write_enable) begin
            we_count++;
            we_addr = addr;
            we_data = write_data;
        end
        if (read_enable) re_count++;
        if (read_enable_0) re_count_0++;
        if (write_enable_0) we_count_0++;
    end

    always @(negedge clock) begin
        if (rsp_valid_0) begin
            if (sb0.size() == 0) begin
                checkOutput("unexpected_rsp_ws0", 32'd1, 32'd0);
            end else begin
                e0x = sb0.pop_front();
                checkOutput("rsp_cycle_ws0", cyc, e0x.due);
                checkOutput("rsp_rdata_ws0", {16'd0, rsp_rdata_0}, {16'd0, e0x.rdata});
                checkOutput("rsp_error_ws0", {31'd0, rsp_error_0}, {31'd0, e0x.err});
            end
        end
    end

    // Called at a falling edge; returns the cycle number of the handshake edge.
    task automatic applyStimulus(input bit sel0, input logic wr, input logic [7:0] a,
                                 input logic [15:0] wd, input logic [15:0] exp_rdata,
                                 input logic exp_err, input int latency,
                                 input bit push, input bit hold, output int e0);
        int n;
        exp_t ex;
        n = 0;
        if (sel0) begin
            req_valid_0 = 1; req_write_0 = wr; req_addr_0 = a; req_wdata_0 = wd;
            while (!req_ready_0 && n < 50) begin @(negedge clock); n++; end
        end else begin
            req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd;
            while (!req_ready && n < 50) begin @(negedge clock); n++; end
        end
        if (n >= 50) checkOutput("req_ready_timeout", 32'd0, 32'd1);
        e0 = cyc + 1;
        ex.due = e0 + latency;
        ex.rdata = exp_rdata;
        ex.err = exp_err;
        if (push) begin
            if (sel0) sb0.push_back(ex);
            else      sb1.push_back(ex);
        end
        @(negedge clock);
        if (!hold) begin
            req_valid = 0;
            req_valid_0 = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb1.size() != 0 || sb0.size() != 0) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) checkOutput("drain_timeout", sb1.size() + sb0.size(), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int e0a, e0b, we0, re0;
        repeat (2) @(negedge clock);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_rsp", {29'd0, rsp_valid, rsp_error, irq_out}, 32'd0);
        checkOutput("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        checkOutput("reset_bus", {addr, write_data, 6'd0, write_enable, read_enable}, 32'd0);
        reset_n = 1;
        @(negedge clock);

        we0 = we_count; re0 = re_count;
        applyStimulus(0, 1, 8'h04, 16'hA5A5, 16'h0000, 0, 4, 1, 0, e0a);
        drain();
        checkOutput("store_write_cycles", we_count - we0, 32'd1);
        checkOutput("store_read_cycles", re_count - re0, 32'd0);
        checkOutput("store_we_addr", {24'd0, we_addr}, 32'h04);
        checkOutput("store_we_data", {16'd0, we_data}, 32'hA5A5);

        we0 = we_count; re0 = re_count;
        rd_value = 16'h1234;
        applyStimulus(0, 0, 8'h08, 16'hFFFF, 16'h1234, 0, 4, 1, 0, e0a);
        drain();
        checkOutput("load_read_cycles", re_count - re0, 32'd2);
        checkOutput("load_write_cycles", we_count - we0, 32'd0);
        checkOutput("idle_addr_hold", {24'd0, addr}, 32'h08);

        we0 = we_count; re0 = re_count;
        applyStimulus(0, 0, 8'h20, 16'h0000, 16'h0000, 1, 1, 1, 0, e0a);
        drain();
        checkOutput("unmapped_strobes", (we_count - we0) + (re_count - re0), 32'd0);

        we0 = we_count;
        applyStimulus(0, 1, 8'h04, 16'h1111, 16'h0000, 0, 4, 1, 1, e0a);
        applyStimulus(0, 1, 8'h0C, 16'h2222, 16'h0000, 0, 4, 1, 0, e0b);
        drain();
        checkOutput("b2b_accept_gap", e0b - e0a, 32'd5);
        checkOutput("b2b_write_cycles", we_count - we0, 32'd2);
        checkOutput("b2b_last_we_data", {16'd0, we_data}, 32'h2222);

        rd_value = 16'h5555;
        applyStimulus(0, 0, 8'h08, 16'h0000, 16'h0000, 0, 4, 0, 0, e0a);
        @(negedge clock);
        checkOutput("midreset_in_access", {31'd0, read_enable}, 32'd1);
        reset_n = 0;
        #1;
        checkOutput("midreset_strobes", {30'd0, read_enable, write_enable}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        repeat (6) @(negedge clock);
        rd_value = 16'h0BEE;
        applyStimulus(0, 0, 8'h00, 16'h0000, 16'h0BEE, 0, 4, 1, 0, e0a);
        drain();

        re0 = re_count_0; we0 = we_count_0;
        rd_value_0 = 16'h7777;
        applyStimulus(1, 0, 8'h0C, 16'h0000, 16'h7777, 0, 3, 1, 0, e0a);
        drain();
        checkOutput("ws0_read_cycles", re_count_0 - re0, 32'd1);
        checkOutput("ws0_write_cycles", we_count_0 - we0, 32'd0);

        checkOutput("irq_out_before", {30'd0, irq_out_0, irq_out}, 32'd0);
        irq = 1;
        @(negedge clock);
        checkOutput("irq_out_delayed", {30'd0, irq_out_0, irq_out}, 32'd3);
        irq = 0;
        @(negedge clock);
        checkOutput("irq_out_pulse_end", {30'd0, irq_out_0, irq_out}, 32'd0);

        checkOutput("strobe_overlap", overlap, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
